// File: rtl/seg_pkg.sv
// Shared seven-segment codes (active-low, bit7 = dp) and scan-state type.
// The encoder here and the segment-to-digit decoder both use these codes.
package seg_pkg;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [1:0] AN_POS1 = 2'b10;
  localparam logic [1:0] AN_POS2 = 2'b01;
  localparam logic [1:0] AN_OFF  = 2'b11;

  typedef enum logic [1:0] {
    SHOW1 = 2'd0,
    GAP1  = 2'd1,
    SHOW2 = 2'd2,
    GAP2  = 2'd3
  } scan_state_t;

endpackage

// File: rtl/dec_to_seg_scan_if.sv
// Digit load / display bus between result logic and the scanned display driver.
interface dec_to_seg_scan_if;

  logic       load;
  logic [3:0] dig1_in;
  logic [3:0] dig2_in;
  logic       lz_blank;
  logic       busy;
  logic [7:0] seg;
  logic [1:0] an;

  modport master (output load, dig1_in, dig2_in, lz_blank,
                  input  busy, seg, an);

  modport slave  (input  load, dig1_in, dig2_in, lz_blank,
                  output busy, seg, an);

endinterface

// File: rtl/bcd_to_seg.sv
// Combinational BCD to active-low seven-segment encoder; non-BCD codes show a dash.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] dig,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (dig)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/dec_to_seg_scan.sv
// Two-digit common-anode display driver: latches BCD digits and time-multiplexes
// them with dark gaps between positions to avoid ghosting.
module dec_to_seg_scan
  import seg_pkg::*;
#(
  parameter int SHOW_CYCLES = 50000,
  parameter int GAP_CYCLES  = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  dec_to_seg_scan_if.slave  bus
);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  scan_state_t      state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             adv;
  logic [3:0]       d1, d2;
  logic             busy_r, s1_seen;
  logic [7:0]       seg_r, seg_nxt, enc_seg;
  logic [1:0]       an_r, an_nxt;
  logic [3:0]       enc_dig;
  logic             enc_blank;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    adv       = 1'b0;
    case (state)
      SHOW1:   if (cnt == SHOW_LAST) begin adv = 1'b1; state_nxt = GAP1;  end
      GAP1:    if (cnt == GAP_LAST)  begin adv = 1'b1; state_nxt = SHOW2; end
      SHOW2:   if (cnt == SHOW_LAST) begin adv = 1'b1; state_nxt = GAP2;  end
      default: if (cnt == GAP_LAST)  begin adv = 1'b1; state_nxt = SHOW1; end
    endcase
    if (adv) cnt_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GAP2;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Encoder sees the digit of the state being entered; lz_blank is taken live.
  assign enc_dig   = (state_nxt == SHOW1) ? d1 : d2;
  assign enc_blank = (state_nxt == SHOW1) && bus.lz_blank && (d1 == 4'd0);

  bcd_to_seg u_enc (
    .dig   (enc_dig),
    .blank (enc_blank),
    .seg   (enc_seg)
  );

  // Outputs change only on state entry, so a lit digit never changes mid-SHOW.
  always_comb begin
    seg_nxt = seg_r;
    an_nxt  = an_r;
    if (adv) begin
      case (state_nxt)
        SHOW1:   begin an_nxt = AN_POS1; seg_nxt = enc_seg;   end
        SHOW2:   begin an_nxt = AN_POS2; seg_nxt = enc_seg;   end
        default: begin an_nxt = AN_OFF;  seg_nxt = SEG_BLANK; end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_r <= SEG_BLANK;
      an_r  <= AN_OFF;
    end else begin
      seg_r <= seg_nxt;
      an_r  <= an_nxt;
    end
  end

  // busy drops only after a SHOW1 entered after the latest load, then its SHOW2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1      <= 4'd0;
      d2      <= 4'd0;
      busy_r  <= 1'b0;
      s1_seen <= 1'b0;
    end else if (bus.load) begin
      d1      <= bus.dig1_in;
      d2      <= bus.dig2_in;
      busy_r  <= 1'b1;
      s1_seen <= 1'b0;
    end else if (adv && state_nxt == SHOW1 && busy_r) begin
      s1_seen <= 1'b1;
    end else if (adv && state == SHOW2 && s1_seen) begin
      busy_r  <= 1'b0;
      s1_seen <= 1'b0;
    end
  end

  assign bus.seg  = seg_r;
  assign bus.an   = an_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_dec_to_seg_scan.sv
// Bench for dec_to_seg_scan: scan-position reference model plus literal checks.
module tb_dec_to_seg_scan;

  localparam int S = 4;
  localparam int G = 2;
  localparam int P = 2 * S + 2 * G;

  logic clk = 1'b0;
  logic rst = 1'b0;

  dec_to_seg_scan_if bus ();

  dec_to_seg_scan #(
    .SHOW_CYCLES (S),
    .GAP_CYCLES  (G),
    .CNT_W       (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] enc_ref(input logic [3:0] d, input logic blank);
    if (blank) return 8'hFF;
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hBF;
    endcase
  endfunction

  function automatic bit is_entry(input int p);
    return (p == 0) || (p == S) || (p == S + G) || (p == 2 * S + G);
  endfunction

  // Model: k counts edges since reset release; scan position follows by modulo.
  int         k      = 0;
  int         m_ph   = P - G;
  int         load_k = -1000;
  logic       m_busy = 1'b0;
  logic [3:0] m_d1   = 4'd0;
  logic [3:0] m_d2   = 4'd0;
  logic [7:0] m_seg  = 8'hFF;
  logic [1:0] m_an   = 2'b11;

  always @(posedge clk) begin
    if (rst) begin
      k = 0; m_ph = P - G; load_k = -1000; m_busy = 1'b0;
      m_d1 = 4'd0; m_d2 = 4'd0; m_seg = 8'hFF; m_an = 2'b11;
    end else begin
      k++;
      m_ph = ((k - G) % P + P) % P;
      if (m_ph == 0) begin
        m_an  = 2'b10;
        m_seg = enc_ref(m_d1, bus.lz_blank && (m_d1 == 4'd0));
      end else if (m_ph == S + G) begin
        m_an  = 2'b01;
        m_seg = enc_ref(m_d2, 1'b0);
      end else if (m_ph == S || m_ph == 2 * S + G) begin
        m_an  = 2'b11;
        m_seg = 8'hFF;
      end
      if (m_ph == 2 * S + G && (k - (2 * S + G)) > load_k) m_busy = 1'b0;
      if (bus.load) begin
        m_d1 = bus.dig1_in; m_d2 = bus.dig2_in; m_busy = 1'b1; load_k = k;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("model_seg", 32'(bus.seg), 32'(m_seg));
    chk("model_an", 32'(bus.an), 32'(m_an));
    chk("model_busy", 32'(bus.busy), 32'(m_busy));
    chk("an_both_low", 32'(bus.an == 2'b00), 32'd0);
    if (bus.an == 2'b11) chk("dark_seg", 32'(bus.seg), 32'hFF);
  end

  task automatic wait_ph(input int ph);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (m_ph != ph && n < 3 * P);
    if (m_ph != ph) begin
      n_chk++; n_fail++;
      $display("FAIL wait_ph: got phase %0d, expected %0d", m_ph, ph);
    end
  endtask

  task automatic do_load(input logic [3:0] a, input logic [3:0] b);
    @(negedge clk);
    bus.load = 1'b1; bus.dig1_in = a; bus.dig2_in = b;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic load_at(input int ph, input logic [3:0] a, input logic [3:0] b);
    wait_ph((ph - 1 + P) % P);
    do_load(a, b);
  endtask

  task automatic lit(input string name, input logic [7:0] s, input logic [1:0] a);
    chk({name, "_seg"}, 32'(bus.seg), 32'(s));
    chk({name, "_an"}, 32'(bus.an), 32'(a));
  endtask

  initial begin
    bus.load = 1'b0; bus.dig1_in = 4'd0; bus.dig2_in = 4'd0; bus.lz_blank = 1'b0;
    #1 rst = 1'b1;
    #1;
    lit("reset", 8'hFF, 2'b11);
    chk("reset_busy", 32'(bus.busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // asynchronous reset in the middle of SHOW2
    load_at(11, 4'd4, 4'd4);
    wait_ph(S + G + 1);
    lit("pre_rst", 8'h99, 2'b01);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    #3 rst = 1'b1;
    #1;
    lit("async_rst", 8'hFF, 2'b11);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_ph(0);
    lit("first_show1", 8'hC0, 2'b10);

    // load 3,7
    load_at(11, 4'd3, 4'd7);
    wait_ph(0);     lit("l37_s1", 8'hB0, 2'b10);
    chk("l37_busy_s1", 32'(bus.busy), 32'd1);
    wait_ph(S);     lit("l37_gap1", 8'hFF, 2'b11);
    wait_ph(S + G); lit("l37_s2", 8'hF8, 2'b01);
    chk("l37_busy_s2", 32'(bus.busy), 32'd1);
    wait_ph(2 * S + G);
    chk("l37_busy_done", 32'(bus.busy), 32'd0);

    // leading-zero blanking
    bus.lz_blank = 1'b1;
    load_at(11, 4'd0, 4'd5);
    wait_ph(0);     lit("lz_s1", 8'hFF, 2'b10);
    wait_ph(S + G); lit("lz_s2", 8'h92, 2'b01);
    bus.lz_blank = 1'b0;
    wait_ph(0);     lit("nolz_s1", 8'hC0, 2'b10);

    // invalid BCD
    load_at(11, 4'd12, 4'd9);
    wait_ph(0);     lit("inv_s1", 8'hBF, 2'b10);
    wait_ph(S + G); lit("inv_s2", 8'h90, 2'b01);

    // load during SHOW1
    load_at(11, 4'd1, 4'd2);
    wait_ph(0);     lit("mid_s1a", 8'hF9, 2'b10);
    do_load(4'd8, 4'd8);
    wait_ph(2);     lit("mid_s1b", 8'hF9, 2'b10);
    wait_ph(3);     lit("mid_s1c", 8'hF9, 2'b10);
    wait_ph(S + G); lit("mid_s2", 8'h80, 2'b01);
    wait_ph(2 * S + G);
    chk("mid_busy_hold", 32'(bus.busy), 32'd1);
    wait_ph(0);     lit("mid_next_s1", 8'h80, 2'b10);
    chk("mid_busy_s1", 32'(bus.busy), 32'd1);
    wait_ph(2 * S + G);
    chk("mid_busy_done", 32'(bus.busy), 32'd0);

    // encoder sweep on position 1
    for (int d = 0; d < 16; d++) begin
      load_at(11, 4'(d), 4'(15 - d));
      wait_ph(0);
      chk("sweep_d1", 32'(bus.seg), 32'(enc_ref(4'(d), 1'b0)));
    end

    // random loads, never on a state-entry edge
    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, P - 1)) begin @(posedge clk); #1; end
      while (is_entry((m_ph + 1) % P)) begin @(posedge clk); #1; end
      @(negedge clk);
      bus.load = 1'b1;
      bus.dig1_in = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      bus.dig2_in = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) bus.lz_blank = ~bus.lz_blank;
      @(negedge clk);
      bus.load = 1'b0;
    end
    repeat (3 * P) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
